// File: rtl/oam_dma_ctl_pkg.sv
// Shared definitions for the OAM DMA controller.
//   - register / window addresses used by the port decoder
//   - DMA sequencer state encoding and registered read-select encoding
//   - dma_src_hi(): maps the DMA register value to the source page
package oam_dma_ctl_pkg;

  localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
  localparam logic [15:0] OAM_BASE       = 16'hFE00;
  localparam int          OAM_LEN        = 160;
  localparam logic [15:0] DMA_ALLOW_BASE = 16'hFF00;
  localparam logic [7:0]  OAM_LAST_IDX   = 8'(OAM_LEN - 1);

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER
  } dma_state_t;

  // What cpu_r_data shows in the cycle after a CPU read strobe.
  typedef enum logic [1:0] {
    RD_NONE,
    RD_MEM,
    RD_REG,
    RD_BLOCKED
  } rd_sel_t;

  // Pages E0-FF alias the work RAM echo region, so fold them down by 0x20.
  function automatic logic [7:0] dma_src_hi(input logic [7:0] page);
    return (page >= 8'hE0) ? (page - 8'h20) : page;
  endfunction

endpackage

// File: rtl/oam_dma_ctl.sv
// oam_dma_ctl: memory-port arbiter and OAM DMA sequencer between the CPU
// memory bus and the system memory port.
//
// A write to FF46 loads the DMA register and, after a CYCLES_PER_BYTE-clock
// start delay, copies 160 bytes from {src_hi,8'h00} to FE00-FE9F, one byte
// every CYCLES_PER_BYTE clocks. While copying, CPU accesses below FF00 are
// blocked; allowed CPU accesses win their port and stall the DMA phase that
// needed it.
//
// Configuration macro: OAM_DMA_BUS_CONFLICT_EN
//   defined   - blocked CPU reads return the last byte the DMA fetched
//   undefined - blocked CPU reads return 8'hFF
//
// Parameters:
//   CYCLES_PER_BYTE  clocks per byte and start-delay length, legal 3..15
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cpu_r_addr/cpu_r_en core read request; cpu_r_data valid one clock later
//   cpu_w_addr/_data/_wen core write request
//   mem_r_addr/mem_r_data memory read port (data one clock after address)
//   mem_w_addr/_data/_wen memory write port
//   dma_active          high while bytes are being copied
//
// Handshake: there is no ready/valid; every strobe is accepted in the cycle
// it is presented. Read data (CPU and memory) always follows one clock after
// the address. Blocked writes vanish, blocked reads still produce data.
module oam_dma_ctl
  import oam_dma_ctl_pkg::*;
#(
  parameter int CYCLES_PER_BYTE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_r_addr,
  input  logic        cpu_r_en,
  output logic [7:0]  cpu_r_data,
  input  logic [15:0] cpu_w_addr,
  input  logic [7:0]  cpu_w_data,
  input  logic        cpu_w_wen,
  output logic [15:0] mem_r_addr,
  input  logic [7:0]  mem_r_data,
  output logic [15:0] mem_w_addr,
  output logic [7:0]  mem_w_data,
  output logic        mem_w_wen,
  output logic        dma_active
);

  localparam logic [3:0] LAST_PHASE = 4'(CYCLES_PER_BYTE - 1);

  dma_state_t  state_q, state_d;
  logic [7:0]  dma_reg_q;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  phase_q, phase_d;
  logic [7:0]  dma_buf_q;
  rd_sel_t     rd_sel_q, rd_sel_d;

  logic        dma_wr;
  logic        xfer;
  logic        cpu_r_allow;
  logic        cpu_w_allow;
  logic        dma_need_r;
  logic        dma_need_w;
  logic        stall;
  logic [15:0] src_addr;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  assign dma_wr      = cpu_w_wen && (cpu_w_addr == DMA_REG_ADDR);
  assign xfer        = (state_q == DMA_XFER);
  assign cpu_r_allow = cpu_r_en && (cpu_r_addr >= DMA_ALLOW_BASE);
  assign cpu_w_allow = cpu_w_wen && (cpu_w_addr >= DMA_ALLOW_BASE) && !dma_wr;
  assign dma_need_r  = xfer && (phase_q == 4'd0);
  assign dma_need_w  = xfer && (phase_q == 4'd2);
  // An allowed CPU access holds the port; the DMA repeats the same phase.
  assign stall       = (dma_need_r && cpu_r_allow) || (dma_need_w && cpu_w_allow);
  assign src_addr    = {dma_src_hi(dma_reg_q), idx_q};
  assign dma_active  = xfer;

  // ---------------------------------------------------------------------
  // Port mux
  // ---------------------------------------------------------------------
  always_comb begin
    mem_r_addr = cpu_r_addr;
    if (dma_need_r && !cpu_r_allow) begin
      mem_r_addr = src_addr;
    end
  end

  always_comb begin
    mem_w_addr = cpu_w_addr;
    mem_w_data = cpu_w_data;
    mem_w_wen  = cpu_w_wen && !dma_wr;
    if (xfer && !cpu_w_allow) begin
      if (dma_need_w) begin
        mem_w_addr = OAM_BASE + 16'(idx_q);
        mem_w_data = dma_buf_q;
        mem_w_wen  = 1'b1;
      end else begin
        // Blocked CPU write (or no write at all): nothing reaches memory.
        mem_w_wen  = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read-data select, registered to line up with the one-clock latency
  // ---------------------------------------------------------------------
  always_comb begin
    rd_sel_d = RD_NONE;
    if (cpu_r_en) begin
      if (cpu_r_addr == DMA_REG_ADDR) begin
        rd_sel_d = RD_REG;
      end else if (xfer && (cpu_r_addr < DMA_ALLOW_BASE)) begin
        rd_sel_d = RD_BLOCKED;
      end else begin
        rd_sel_d = RD_MEM;
      end
    end
  end

  always_comb begin
    cpu_r_data = 8'hFF;
    case (rd_sel_q)
      RD_MEM:     cpu_r_data = mem_r_data;
      RD_REG:     cpu_r_data = dma_reg_q;
`ifdef OAM_DMA_BUS_CONFLICT_EN
      RD_BLOCKED: cpu_r_data = dma_buf_q;
`else
      RD_BLOCKED: cpu_r_data = 8'hFF;
`endif
      default:    cpu_r_data = 8'hFF;
    endcase
  end

  // ---------------------------------------------------------------------
  // Sequencer next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    case (state_q)
      DMA_IDLE: begin
        state_d = DMA_IDLE;
      end
      DMA_START: begin
        // phase doubles as the start-delay counter
        if (phase_q == LAST_PHASE) begin
          state_d = DMA_XFER;
          phase_d = 4'd0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      DMA_XFER: begin
        if (!stall) begin
          if (phase_q == LAST_PHASE) begin
            phase_d = 4'd0;
            if (idx_q == OAM_LAST_IDX) begin
              state_d = DMA_IDLE;
              idx_d   = 8'd0;
            end else begin
              idx_d   = idx_q + 8'd1;
            end
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = DMA_IDLE;
        idx_d   = 8'd0;
        phase_d = 4'd0;
      end
    endcase
    // A register write restarts from scratch, overriding a completion.
    if (dma_wr) begin
      state_d = DMA_START;
      idx_d   = 8'd0;
      phase_d = 4'd0;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DMA_IDLE;
      dma_reg_q <= 8'hFF;
      idx_q     <= 8'd0;
      phase_q   <= 4'd0;
      dma_buf_q <= 8'hFF;
      rd_sel_q  <= RD_NONE;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      rd_sel_q  <= rd_sel_d;
      if (dma_wr) begin
        dma_reg_q <= cpu_w_data;
      end
      // Phase 1 never stalls, so this captures the phase-0 read exactly once.
      if (xfer && (phase_q == 4'd1)) begin
        dma_buf_q <= mem_r_data;
      end
    end
  end

endmodule
